// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI slave front end.
//   spi_state_e : 3-bit FSM state encoding
//   WR_ADDR/WR_DATA/RD_ADDR/RD_DATA : 2-bit command codes carried in frame[FRAME_W-1:FRAME_W-2]
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4,
    RD_WAIT   = 3'd5,
    RD_SHIFT  = 3'd6,
    HOLD      = 3'd7
  } spi_state_e;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  // The first frame bit alone separates writes from reads.
  function automatic logic is_read_cmd(input logic cmd_msb);
    return cmd_msb == RD_ADDR[1];
  endfunction

endpackage

// File: rtl/spi_shift_out.sv
// spi_shift_out: DATA_W parallel-load, MSB-first, zero-filling shifter.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : force register (and sout) to zero
//   load, din : parallel load; sout shows din[DATA_W-1] the next cycle
//   en        : shift one place toward the MSB, zero fill
//   sout      : registered serial output (sh MSB)
//   done      : the last bit (original din[0]) is currently on sout
module spi_shift_out #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic              sout,
  output logic              done
);
  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sh;
  logic [CW-1:0]     cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= din;
      cnt <= '0;
    end else if (en) begin
      sh  <= sh << 1;
      cnt <= cnt + 1'b1;
    end
  end

  assign sout = sh[DATA_W-1];
  assign done = (cnt == CW'(DATA_W - 1));

endmodule

// File: rtl/spi_slave_param.sv
// spi_slave_param: parametrised SPI slave front end.
//   clk, rst  : serial clock (rising edge), synchronous active-high reset
//   SS_n      : slave select, active low
//   MOSI      : serial data in, sampled MSB first
//   tx_valid, tx_data : read data from memory, accepted only while waiting for it
//   MISO      : registered serial data out
//   rx_valid  : one-cycle pulse, rx_data holds a newly completed frame
//   rx_data   : last completed frame {cmd[1:0], payload}
//   frame_err : one-cycle pulse, SS_n rose before the frame/transfer finished
//   busy      : FSM not idle
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 3)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              MISO,
  output logic              rx_valid,
  output logic [DATA_W+1:0] rx_data,
  output logic              frame_err,
  output logic              busy
);
  localparam int FRAME_W = DATA_W + 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

  spi_state_e         state, nstate;
  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-2:0] rx_sh;   // bits received so far; MOSI supplies bit 0
  logic               addr_saved;

  logic shift_in, frame_done, set_addr, clr_addr, abort;
  logic sh_load, sh_en, sh_clr, sh_done;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate     = state;
    shift_in   = 1'b0;
    frame_done = 1'b0;
    set_addr   = 1'b0;
    clr_addr   = 1'b0;
    abort      = 1'b0;
    sh_load    = 1'b0;
    sh_en      = 1'b0;
    if (state != IDLE && SS_n) begin
      // Deselect wins in every active state; only HOLD is a clean end.
      nstate = IDLE;
      abort  = (state != HOLD);
    end else begin
      case (state)
        IDLE:    if (!SS_n) nstate = CHK_CMD;
        CHK_CMD: begin
          shift_in = 1'b1;
          if (!is_read_cmd(MOSI)) nstate = WRITE;
          else if (addr_saved)    nstate = READ_DATA;
          else                    nstate = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          shift_in = 1'b1;
          if (cnt == LAST) begin
            frame_done = 1'b1;
            set_addr   = (state == READ_ADD);
            nstate     = (state == READ_DATA) ? RD_WAIT : HOLD;
          end
        end
        RD_WAIT: if (tx_valid) begin
          sh_load = 1'b1;
          nstate  = RD_SHIFT;
        end
        RD_SHIFT: begin
          // The shift at done leaves the zero-filled register empty, so
          // MISO drops to 0 as we enter HOLD.
          sh_en = 1'b1;
          if (sh_done) begin
            clr_addr = 1'b1;
            nstate   = HOLD;
          end
        end
        HOLD:    nstate = HOLD;
        default: nstate = IDLE;
      endcase
    end
  end

  // Anything other than an active load/shift parks MISO at 0.
  assign sh_clr = !(sh_load || sh_en);

  spi_shift_out #(.DATA_W(DATA_W)) u_shift_out (
    .clk  (clk),
    .rst  (rst),
    .clr  (sh_clr),
    .load (sh_load),
    .en   (sh_en),
    .din  (tx_data),
    .sout (MISO),
    .done (sh_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      rx_sh      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      addr_saved <= 1'b0;
    end else begin
      rx_valid  <= frame_done;
      frame_err <= abort;
      if (set_addr)      addr_saved <= 1'b1;
      else if (clr_addr) addr_saved <= 1'b0;
      if (nstate == IDLE) begin
        cnt <= '0;
      end else if (shift_in) begin
        cnt   <= (state == CHK_CMD) ? CNT_W'(1) : cnt + 1'b1;
        rx_sh <= {rx_sh[FRAME_W-3:0], MOSI};
      end
      if (frame_done) rx_data <= {rx_sh, MOSI};
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_slave_param.sv
// tb_spi_slave_param: directed + randomized bench for spi_slave_param.
// Two instances: DATA_W=8 (main) and DATA_W=16 (width sweep). Inputs are
// driven and outputs sampled on the falling edge.
module tb_spi_slave_param;
  localparam int W   = 8;
  localparam int FW  = W + 2;
  localparam int W2  = 16;
  localparam int FW2 = W2 + 2;

  logic clk = 1'b0;
  logic rst, ss_n, mosi, tx_valid;
  logic [W-1:0] tx_data;
  logic miso, rx_valid, frame_err, busy;
  logic [FW-1:0] rx_data;

  logic ss_n2, mosi2, tx_valid2;
  logic [W2-1:0] tx_data2;
  logic miso2, rx_valid2, frame_err2, busy2;
  logic [FW2-1:0] rx_data2;

  int checks   = 0;
  int failures = 0;

  // Reference state: last completed frame and whether a read address is held.
  logic [FW-1:0] m_rx;
  bit            m_addr;

  always #5 clk = ~clk;

  spi_slave_param #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .tx_valid(tx_valid),
    .tx_data(tx_data), .MISO(miso), .rx_valid(rx_valid), .rx_data(rx_data),
    .frame_err(frame_err), .busy(busy)
  );

  spi_slave_param #(.DATA_W(W2)) dut16 (
    .clk(clk), .rst(rst), .SS_n(ss_n2), .MOSI(mosi2), .tx_valid(tx_valid2),
    .tx_data(tx_data2), .MISO(miso2), .rx_valid(rx_valid2), .rx_data(rx_data2),
    .frame_err(frame_err2), .busy(busy2)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Select, then clock in the top nbits of f MSB first; rx_valid must rise
  // only right after bit 0.
  task automatic frame8(input logic [FW-1:0] f, input int nbits);
    ss_n = 1'b0;
    tick();
    chk("busy_start", busy, 1);
    for (int i = FW - 1; i >= FW - nbits; i--) begin
      mosi = f[i];
      tick();
      chk("rx_valid_timing", rx_valid, (i == 0));
      chk("frame_err_quiet", frame_err, 0);
    end
  endtask

  // Full frame against the model: reads with a saved address return d
  // after wt extra idle cycles of tx_valid.
  task automatic run_frame(input logic [FW-1:0] f, input int wt, input logic [W-1:0] d);
    bit rd;
    rd = f[FW-1] && m_addr;
    if (f[FW-1] && !m_addr) m_addr = 1'b1;
    m_rx = f;
    frame8(f, FW);
    tx_valid = rd ? 1'b0 : 1'b1;   // outside the read wait tx_valid is ignored
    tx_data  = ~d;
    mosi     = 1'($urandom);
    tick();
    chk("rx_valid_pulse", rx_valid, 0);
    chk("rx_data", rx_data, m_rx);
    chk("miso_quiet", miso, 0);
    if (rd) begin
      repeat (wt) begin
        tick();
        chk("miso_wait", miso, 0);
      end
      tx_valid = 1'b1;
      tx_data  = d;
      tick();
      tx_valid = 1'b0;
      tx_data  = W'($urandom);
      for (int b = W - 1; b >= 0; b--) begin
        chk("miso_bit", miso, d[b]);
        tick();
      end
      chk("miso_after", miso, 0);
      m_addr = 1'b0;
    end
    chk("addr_saved", dut.addr_saved, m_addr);
    ss_n     = 1'b1;
    tx_valid = 1'b0;
    tick();
    chk("end_frame_err", frame_err, 0);
    chk("end_busy", busy, 0);
    chk("end_miso", miso, 0);
  endtask

  initial begin
    logic [FW-1:0]  f;
    logic [FW2-1:0] f2;
    logic [W-1:0]   d;

    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    ss_n2 = 1'b1; mosi2 = 1'b0; tx_valid2 = 1'b0; tx_data2 = '0;
    m_rx = '0; m_addr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_miso", miso, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr_saved", dut.addr_saved, 0);
    chk("rst_rx_data16", rx_data2, 0);

    // Write address, then read address, then read data with a slow memory.
    run_frame(10'h0A5, 0, 8'h00);
    chk("wr_rx_data", rx_data, 10'h0A5);
    run_frame(10'h207, 0, 8'h00);
    chk("rdaddr_saved", dut.addr_saved, 1);
    run_frame(10'h3A6, 4, 8'hC3);

    // Abort a write after 4 bits: error pulse, rx_data untouched.
    frame8(10'h05A, 4);
    ss_n = 1'b1;
    tick();
    chk("abort_frame_err", frame_err, 1);
    chk("abort_rx_valid", rx_valid, 0);
    chk("abort_busy", busy, 0);
    tick();
    chk("abort_err_pulse", frame_err, 0);
    chk("abort_rx_keep", rx_data, m_rx);
    run_frame(10'h15A, 0, 8'h00);

    // Abort in the middle of a read shift: address stays saved, retry works.
    run_frame(10'h211, 0, 8'h00);
    f = 10'h3FF; d = 8'h9D;
    frame8(f, FW);
    m_rx = f;
    tx_valid = 1'b1; tx_data = d;
    tick();
    tx_valid = 1'b0;
    for (int b = W - 1; b > W - 4; b--) begin
      chk("abort_rd_bit", miso, d[b]);
      tick();
    end
    ss_n = 1'b1;
    tick();
    chk("rdabort_frame_err", frame_err, 1);
    chk("rdabort_miso", miso, 0);
    chk("rdabort_addr_saved", dut.addr_saved, 1);
    tick();
    chk("rdabort_err_pulse", frame_err, 0);
    run_frame(10'h300, 2, 8'h5E);

    // Reset during a read shift clears everything including addr_saved.
    run_frame(10'h2C4, 0, 8'h00);
    frame8(10'h3C4, FW);
    m_rx = 10'h3C4;
    tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    tx_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    m_rx = '0; m_addr = 1'b0;
    chk("rstsh_miso", miso, 0);
    chk("rstsh_busy", busy, 0);
    chk("rstsh_rx_data", rx_data, 0);
    chk("rstsh_addr_saved", dut.addr_saved, 0);
    ss_n = 1'b1; rst = 1'b0;
    tick();
    run_frame(10'h2F0, 0, 8'h00);   // enters READ_ADD again

    // Reset on the edge that would complete a frame suppresses the pulse.
    frame8(10'h0F3, FW - 1);
    mosi = 1'b1; rst = 1'b1;
    tick();
    chk("rstpend_rx_valid", rx_valid, 0);
    chk("rstpend_rx_data", rx_data, 0);
    ss_n = 1'b1; rst = 1'b0; m_rx = '0; m_addr = 1'b0;
    tick();

    // Randomized frames against the model.
    for (int n = 0; n < 24; n++) begin
      f = FW'($urandom);
      d = W'($urandom);
      run_frame(f, $urandom_range(0, 4), d);
    end

    // Width sweep: 18-bit frame on the DATA_W=16 instance.
    f2 = 18'h2ABCD;
    ss_n2 = 1'b0;
    tick();
    for (int i = FW2 - 1; i >= 0; i--) begin
      mosi2 = f2[i];
      tick();
      chk("w16_rx_valid", rx_valid2, (i == 0));
    end
    chk("w16_rx_data", rx_data2, 18'h2ABCD);
    tick();
    chk("w16_rx_valid_pulse", rx_valid2, 0);
    ss_n2 = 1'b1;
    tick();
    chk("w16_frame_err", frame_err2, 0);
    chk("w16_busy", busy2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
